// File: rtl/bn_feature_streamer.sv
// bn_feature_streamer: reads a channel-major feature map from a synchronous memory and streams it
// to the BatchNorm+ReLU stage. Each channel's gamma/beta/mean/variance are loaded from a parameter
// memory before its plane and held stable while that plane streams.
module bn_feature_streamer #(
  parameter int unsigned IMG_HEIGHT  = 256,
  parameter int unsigned IMG_WIDTH   = 256,
  parameter int unsigned CHANNELS    = 64,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned PADDR_WIDTH = 8,
  parameter int unsigned CH_WIDTH    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  output logic                   feat_mem_rd,
  output logic [ADDR_WIDTH-1:0]  feat_mem_addr,
  input  logic [DATA_WIDTH-1:0]  feat_mem_rdata,
  output logic                   param_mem_rd,
  output logic [PADDR_WIDTH-1:0] param_mem_addr,
  input  logic [DATA_WIDTH-1:0]  param_mem_rdata,
  output logic [DATA_WIDTH-1:0]  feature_in,
  output logic                   feature_valid,
  output logic [DATA_WIDTH-1:0]  gamma,
  output logic [DATA_WIDTH-1:0]  beta,
  output logic [DATA_WIDTH-1:0]  mean,
  output logic [DATA_WIDTH-1:0]  variance,
  output logic [CH_WIDTH-1:0]    channel_idx,
  output logic                   busy,
  output logic                   stream_done
);

  localparam int unsigned PlanePix = IMG_HEIGHT * IMG_WIDTH;
  localparam int unsigned PixW     = (PlanePix > 1) ? $clog2(PlanePix) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadParams,
    StCommit,
    StStream,
    StDrain
  } state_e;

  state_e state_q, state_d;

  // Running linear feature address, pixel index within the plane, channel and parameter index.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PixW-1:0]       pix_q;
  logic [CH_WIDTH-1:0]   ch_q;
  logic [1:0]            k_q;

  // Shadow copies of the first three parameter words; the fourth lands directly in COMMIT.
  logic [DATA_WIDTH-1:0] gamma_sh_q, beta_sh_q, mean_sh_q;

  // Parameter set presented to the BN stage.
  logic [DATA_WIDTH-1:0] gamma_q, beta_q, mean_q, variance_q;
  logic [CH_WIDTH-1:0]   ch_idx_q;

  logic feat_vld_q;
  logic done_q;

  logic pix_last;
  logic ch_last;
  logic issue;

  assign pix_last = (pix_q == PixW'(PlanePix - 1));
  assign ch_last  = (ch_q == CH_WIDTH'(CHANNELS - 1));
  assign issue    = (state_q == StStream) && !pause;

  assign feat_mem_addr = addr_q;
  assign feature_valid = feat_vld_q;
  assign gamma         = gamma_q;
  assign beta          = beta_q;
  assign mean          = mean_q;
  assign variance      = variance_q;
  assign channel_idx   = ch_idx_q;
  assign stream_done   = done_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadParams;
        end
      end
      StLoadParams: begin
        if (k_q == 2'd3) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d = StStream;
      end
      StStream: begin
        if (issue && pix_last) begin
          state_d = ch_last ? StDrain : StLoadParams;
        end
      end
      StDrain: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode: read strobes, parameter address, busy and gated feature data.
  always_comb begin
    feat_mem_rd    = 1'b0;
    param_mem_rd   = 1'b0;
    param_mem_addr = '0;
    busy           = (state_q != StIdle);
    feature_in     = feat_vld_q ? feat_mem_rdata : '0;
    unique case (state_q)
      StLoadParams: begin
        param_mem_rd   = 1'b1;
        // 4*c + k
        param_mem_addr = PADDR_WIDTH'({ch_q, k_q});
      end
      StStream: begin
        feat_mem_rd = !pause;
      end
      default: begin
      end
    endcase
  end

  // Address/pixel/channel counters; they freeze on the final pixel of the final plane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      pix_q  <= '0;
      ch_q   <= '0;
      k_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q <= '0;
            pix_q  <= '0;
            ch_q   <= '0;
            k_q    <= '0;
          end
        end
        StLoadParams: begin
          // Wraps back to 0 after the variance read, ready for the next plane.
          k_q <= k_q + 2'd1;
        end
        StStream: begin
          if (issue) begin
            if (!pix_last) begin
              pix_q  <= pix_q + PixW'(1);
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end else if (!ch_last) begin
              pix_q  <= '0;
              ch_q   <= ch_q + CH_WIDTH'(1);
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Parameter capture: each word is taken one cycle after its read, all four published in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gamma_sh_q <= '0;
      beta_sh_q  <= '0;
      mean_sh_q  <= '0;
      gamma_q    <= '0;
      beta_q     <= '0;
      mean_q     <= '0;
      variance_q <= '0;
      ch_idx_q   <= '0;
    end else begin
      if (state_q == StLoadParams) begin
        unique case (k_q)
          2'd1:    gamma_sh_q <= param_mem_rdata;
          2'd2:    beta_sh_q  <= param_mem_rdata;
          2'd3:    mean_sh_q  <= param_mem_rdata;
          default: begin
          end
        endcase
      end
      if (state_q == StCommit) begin
        gamma_q    <= gamma_sh_q;
        beta_q     <= beta_sh_q;
        mean_q     <= mean_sh_q;
        variance_q <= param_mem_rdata;
        ch_idx_q   <= ch_q;
      end
    end
  end

  // Read-return tracking and completion pulse; in-flight reads are dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      feat_vld_q <= issue;
      // DRAIN is the cycle carrying the last feature, so the pulse lands just after it.
      done_q     <= (state_q == StDrain);
    end
  end

endmodule

// File: tb/tb_bn_feature_streamer.sv
// Bench for bn_feature_streamer: directed scenarios plus randomized memory contents and pause
// patterns, checked against a plane-by-plane reference timeline built in the bench.
module tb_bn_feature_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic sel = 1'b0;  // 0: 2x2x2 instance, 1: 1x1x1 instance
  logic start0, start1;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  // Instance 0: H=W=2, C=2
  logic        frd0, prd0, fv0, busy0, done0;
  logic [2:0]  faddr0, paddr0;
  logic [15:0] frdata0, prdata0, fin0, g0, b0, m0, v0;
  logic [0:0]  ch0;

  // Instance 1: H=W=1, C=1
  logic        frd1, prd1, fv1, busy1, done1;
  logic [0:0]  faddr1;
  logic [1:0]  paddr1;
  logic [15:0] frdata1, prdata1, fin1, g1, b1, m1, v1;
  logic [0:0]  ch1;

  bn_feature_streamer #(
    .IMG_HEIGHT(2), .IMG_WIDTH(2), .CHANNELS(2), .DATA_WIDTH(16),
    .ADDR_WIDTH(3), .PADDR_WIDTH(3), .CH_WIDTH(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pause(pause),
    .feat_mem_rd(frd0), .feat_mem_addr(faddr0), .feat_mem_rdata(frdata0),
    .param_mem_rd(prd0), .param_mem_addr(paddr0), .param_mem_rdata(prdata0),
    .feature_in(fin0), .feature_valid(fv0),
    .gamma(g0), .beta(b0), .mean(m0), .variance(v0),
    .channel_idx(ch0), .busy(busy0), .stream_done(done0)
  );

  bn_feature_streamer #(
    .IMG_HEIGHT(1), .IMG_WIDTH(1), .CHANNELS(1), .DATA_WIDTH(16),
    .ADDR_WIDTH(1), .PADDR_WIDTH(2), .CH_WIDTH(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .pause(pause),
    .feat_mem_rd(frd1), .feat_mem_addr(faddr1), .feat_mem_rdata(frdata1),
    .param_mem_rd(prd1), .param_mem_addr(paddr1), .param_mem_rdata(prdata1),
    .feature_in(fin1), .feature_valid(fv1),
    .gamma(g1), .beta(b1), .mean(m1), .variance(v1),
    .channel_idx(ch1), .busy(busy1), .stream_done(done1)
  );

  // Synchronous memories with one-cycle read latency.
  logic [15:0] fmem [8];
  logic [15:0] pmem [8];

  always_ff @(posedge clk) begin
    if (frd0) frdata0 <= fmem[faddr0];
    if (prd0) prdata0 <= pmem[paddr0];
    if (frd1) frdata1 <= fmem[faddr1];
    if (prd1) prdata1 <= pmem[paddr1];
  end

  // Observation mux onto the selected instance.
  logic        o_frd, o_prd, o_fv, o_busy, o_done;
  int          o_faddr, o_paddr, o_ch;
  logic [15:0] o_fin;
  logic [63:0] o_par;

  always_comb begin
    if (sel) begin
      o_frd = frd1; o_faddr = 32'(faddr1); o_prd = prd1; o_paddr = 32'(paddr1);
      o_fv = fv1; o_fin = fin1; o_par = {g1, b1, m1, v1}; o_ch = 32'(ch1);
      o_busy = busy1; o_done = done1;
    end else begin
      o_frd = frd0; o_faddr = 32'(faddr0); o_prd = prd0; o_paddr = 32'(paddr0);
      o_fv = fv0; o_fin = fin0; o_par = {g0, b0, m0, v0}; o_ch = 32'(ch0);
      o_busy = busy0; o_done = done0;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  bit pause_plan [256];

  // Expected and observed event logs (cycle numbers relative to the start cycle).
  int          e_rd_c[$], e_rd_a[$], e_pr_c[$], e_pr_a[$], e_v_c[$], e_v_ch[$];
  logic [15:0] e_v_d[$];
  logic [63:0] e_v_p[$];
  int          e_done;
  int          o_rd_c[$], o_rd_a[$], o_pr_c[$], o_pr_a[$], o_v_c[$], o_v_ch[$], o_done_c[$];
  logic [15:0] o_v_d[$];
  logic [63:0] o_v_p[$];
  logic        busy_drain, busy_after;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 8; i++) begin
      fmem[i] = 16'h0100 + 16'(i);
      pmem[i] = 16'h1000 + 16'(i);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      fmem[i] = 16'($urandom);
      pmem[i] = 16'($urandom);
    end
  endtask

  task automatic set_pause(input int lo, input int hi);
    for (int i = 0; i < 256; i++) pause_plan[i] = (i >= lo) && (i <= hi);
  endtask

  // Reference timeline: per plane, 4 parameter reads, one commit cycle, then one read per
  // unpaused cycle; data and parameters are looked up from the memory arrays directly.
  task automatic build_model();
    int t, hw, nc;
    hw = sel ? 1 : 4;
    nc = sel ? 1 : 2;
    e_rd_c.delete(); e_rd_a.delete(); e_pr_c.delete(); e_pr_a.delete();
    e_v_c.delete(); e_v_ch.delete(); e_v_d.delete(); e_v_p.delete();
    t = 1;
    for (int c = 0; c < nc; c++) begin
      for (int k = 0; k < 4; k++) begin
        e_pr_c.push_back(t + k);
        e_pr_a.push_back(4 * c + k);
      end
      t += 5;
      for (int p = 0; p < hw; p++) begin
        while (pause_plan[t]) t++;
        e_rd_c.push_back(t);
        e_rd_a.push_back(c * hw + p);
        e_v_c.push_back(t + 1);
        e_v_d.push_back(fmem[c * hw + p]);
        e_v_p.push_back({pmem[4 * c], pmem[4 * c + 1], pmem[4 * c + 2], pmem[4 * c + 3]});
        e_v_ch.push_back(c);
        t++;
      end
    end
    e_done = t + 1;
  endtask

  task automatic sample(input int rel);
    if (o_frd) begin o_rd_c.push_back(rel); o_rd_a.push_back(o_faddr); end
    if (o_prd) begin o_pr_c.push_back(rel); o_pr_a.push_back(o_paddr); end
    if (o_fv) begin
      o_v_c.push_back(rel); o_v_d.push_back(o_fin);
      o_v_p.push_back(o_par); o_v_ch.push_back(o_ch);
    end
    if (o_done) o_done_c.push_back(rel);
    if (rel == e_done - 1) busy_drain = o_busy;
    if (rel == e_done) busy_after = o_busy;
  endtask

  // One full stream from a start pulse; mid_start re-pulses start at that relative cycle.
  task automatic run_stream(input string name, input int mid_start);
    build_model();
    o_rd_c.delete(); o_rd_a.delete(); o_pr_c.delete(); o_pr_a.delete();
    o_v_c.delete(); o_v_ch.delete(); o_v_d.delete(); o_v_p.delete(); o_done_c.delete();
    busy_drain = 1'bx;
    busy_after = 1'bx;
    @(posedge clk); #1;
    start = 1'b1;
    pause = pause_plan[0];
    for (int rel = 1; rel <= e_done + 2; rel++) begin
      @(posedge clk); #1;
      start = (rel == mid_start);
      pause = pause_plan[rel];
      @(negedge clk);
      sample(rel);
    end
    start = 1'b0;
    pause = 1'b0;

    chk({name, "_n_reads"}, 64'(o_rd_c.size()), 64'(e_rd_c.size()));
    foreach (e_rd_c[i]) if (i < o_rd_c.size()) begin
      chk($sformatf("%s_rd%0d_cyc", name, i), 64'(o_rd_c[i]), 64'(e_rd_c[i]));
      chk($sformatf("%s_rd%0d_addr", name, i), 64'(o_rd_a[i]), 64'(e_rd_a[i]));
    end
    chk({name, "_n_preads"}, 64'(o_pr_c.size()), 64'(e_pr_c.size()));
    foreach (e_pr_c[i]) if (i < o_pr_c.size()) begin
      chk($sformatf("%s_pr%0d_cyc", name, i), 64'(o_pr_c[i]), 64'(e_pr_c[i]));
      chk($sformatf("%s_pr%0d_addr", name, i), 64'(o_pr_a[i]), 64'(e_pr_a[i]));
    end
    chk({name, "_n_valid"}, 64'(o_v_c.size()), 64'(e_v_c.size()));
    foreach (e_v_c[i]) if (i < o_v_c.size()) begin
      chk($sformatf("%s_v%0d_cyc", name, i), 64'(o_v_c[i]), 64'(e_v_c[i]));
      chk($sformatf("%s_v%0d_data", name, i), 64'(o_v_d[i]), 64'(e_v_d[i]));
      chk($sformatf("%s_v%0d_params", name, i), o_v_p[i], e_v_p[i]);
      chk($sformatf("%s_v%0d_ch", name, i), 64'(o_v_ch[i]), 64'(e_v_ch[i]));
    end
    chk({name, "_n_done"}, 64'(o_done_c.size()), 64'd1);
    if (o_done_c.size() > 0) chk({name, "_done_cyc"}, 64'(o_done_c[0]), 64'(e_done));
    chk({name, "_busy_drain"}, 64'(busy_drain), 64'd1);
    chk({name, "_busy_after"}, 64'(busy_after), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, 64'({frd0, prd0, fv0, busy0, done0}), 64'd0);
    chk({tag, "_addrs"}, 64'({faddr0, paddr0}), 64'd0);
    chk({tag, "_params"}, {g0, b0, m0, v0}, 64'd0);
    chk({tag, "_feat_ch"}, 64'({fin0, ch0}), 64'd0);
  endtask

  initial begin
    fill_pattern();
    set_pause(-1, -1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Plain stream: valids in 7-10 and 16-19, done in 20.
    run_stream("plain", -1);
    if (o_v_c.size() == 8) begin
      chk("plain_first_valid", 64'(o_v_c[0]), 64'd7);
      chk("plain_plane1_valid", 64'(o_v_c[4]), 64'd16);
      chk("plain_last_data", 64'(o_v_d[7]), 64'h0107);
    end
    if (o_done_c.size() > 0) chk("plain_done_20", 64'(o_done_c[0]), 64'd20);

    // Pause in cycles 7-9: second item 0x0101 returns in cycle 11.
    set_pause(7, 9);
    run_stream("pause7_9", -1);
    if (o_v_c.size() > 1) begin
      chk("pause_second_cyc", 64'(o_v_c[1]), 64'd11);
      chk("pause_second_data", 64'(o_v_d[1]), 64'h0101);
    end

    // Pause held across LOAD_PARAMS/COMMIT of plane 0.
    set_pause(0, 8);
    run_stream("pause_load", -1);

    // Start re-pulsed mid-stream is ignored.
    set_pause(-1, -1);
    run_stream("mid_start", 12);

    // Asynchronous reset during plane 1 STREAM, then a clean restart.
    @(posedge clk); #1;
    start = 1'b1;
    for (int rel = 1; rel <= 16; rel++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_reset_busy", 64'(busy0), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    run_stream("after_reset", -1);

    // Minimal 1x1x1 configuration.
    sel = 1'b1;
    run_stream("tiny", -1);
    if (o_v_c.size() > 0) chk("tiny_valid_7", 64'(o_v_c[0]), 64'd7);
    if (o_done_c.size() > 0) chk("tiny_done_8", 64'(o_done_c[0]), 64'd8);
    sel = 1'b0;

    // Random memory contents and pause patterns.
    for (int r = 0; r < 8; r++) begin
      fill_random();
      for (int i = 0; i < 256; i++) pause_plan[i] = ($urandom_range(0, 3) == 0);
      run_stream($sformatf("rand%0d", r), (r % 2 == 0) ? 9 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bn_feature_streamer.md
Name: bn_feature_streamer

Overview:
Transmit-side companion to the BatchNorm+ReLU stage. It reads a channel-major feature map from a synchronous feature memory and drives the feature_in/feature_valid stream plus the per-channel gamma, beta, mean and variance that the BatchNorm+ReLU stage consumes. Before each channel plane it loads that channel's four BN parameters from a parameter memory. The parameters stay stable for the whole plane. It supports issue-side backpressure (pause) and reports completion.

Parameters:
IMG_HEIGHT, 256, rows per channel plane
IMG_WIDTH, 256, columns per channel plane
CHANNELS, 64, number of channel planes
DATA_WIDTH, 16, feature and parameter word width
ADDR_WIDTH, 22, feature memory address width; must hold IMG_HEIGHT*IMG_WIDTH*CHANNELS-1
PADDR_WIDTH, 8, parameter memory address width; must hold 4*CHANNELS-1
CH_WIDTH, 6, width of channel_idx; must hold CHANNELS-1

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin one full feature-map stream; sampled only in IDLE
pause  in  1  when high, no new feature read is issued
feat_mem_rd  out  1  feature memory read strobe
feat_mem_addr  out  ADDR_WIDTH  feature address = c*H*W + row*W + col
feat_mem_rdata  in  DATA_WIDTH  feature read data, valid exactly 1 cycle after feat_mem_rd
param_mem_rd  out  1  parameter memory read strobe
param_mem_addr  out  PADDR_WIDTH  4*c+k; k=0 gamma, 1 beta, 2 mean, 3 variance
param_mem_rdata  in  DATA_WIDTH  parameter read data, 1-cycle latency
feature_in  out  DATA_WIDTH  feature word to the BN stage
feature_valid  out  1  feature_in valid this cycle
gamma, beta, mean, variance  out  DATA_WIDTH each  current channel's BN parameters
channel_idx  out  CH_WIDTH  channel currently being streamed
busy  out  1  high in any state other than IDLE
stream_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All outputs 0, including the read strobes, addresses, parameters, channel_idx, busy and stream_done. Internal counters are cleared. In-flight reads are discarded.
- States: IDLE, LOAD_PARAMS, COMMIT, STREAM, DRAIN.
- IDLE:
  - start=1 → go to LOAD_PARAMS with c=0 and pixel counter 0.
  - start in any other state is ignored.
- LOAD_PARAMS: lasts 4 cycles.
  - param_mem_rd=1 with addr 4c+0 … 4c+3 on consecutive cycles.
  - Each returned word is captured into a shadow register one cycle after its read.
  - pause has no effect in this state.
  - Next state: COMMIT.
- COMMIT: lasts 1 cycle.
  - The 4th parameter word is captured.
  - All four shadow values are copied to gamma/beta/mean/variance together; channel_idx is updated to c.
  - Next state: STREAM.
- STREAM:
  - Each cycle with pause=0: feat_mem_rd=1, feat_mem_addr = running linear count, then the counter increments.
  - pause=1: feat_mem_rd=0 and the counter holds.
  - After issuing the last pixel of plane c:
    - if c<CHANNELS-1, c increments and the FSM goes to LOAD_PARAMS;
    - otherwise the FSM goes to DRAIN.
- DRAIN: lasts 1 cycle, then returns to IDLE. stream_done=1 is registered for exactly the cycle after the last feature_valid.
- Data return:
  - feature_valid=1 and feature_in=feat_mem_rdata exactly one cycle after each issued read, independent of pause.
  - As a result, up to 1 item may emerge in the cycle after pause rises.
  - feature_valid is never high without a matching issued read.
  - The feature value is passed through unmodified; no arithmetic is applied.
- Parameter stability:
  - gamma/beta/mean/variance and channel_idx change only in COMMIT.
  - The last feature of plane c appears during the first LOAD_PARAMS cycle of plane c+1, so it is always accompanied by plane c's parameters.
- Timing, with pause=0 and start seen at edge of cycle 0:
  - param_mem_rd in cycles 1–4, COMMIT in cycle 5.
  - First feat_mem_rd in cycle 6, first feature_valid in cycle 7.
  - Per-plane overhead is 5 cycles. Total feature_valid count is H*W*C.
- Addresses wrap: none. The counters stop at their final values, and the linear feature address never exceeds H*W*C-1.

Test Plan:
- H=W=2, C=2; feature mem[i]=0x0100+i; param mem[j]=0x1000+j; start pulse at cycle 0 → feature_valid in cycles 7–10 with data 0x0100–0x0103 and gamma/beta/mean/variance=0x1000–0x1003, channel_idx=0. Then cycles 16–19 with data 0x0104–0x0107 and params 0x1004–0x1007, channel_idx=1. stream_done in cycle 20 only; busy falls after.
- Same config, pause high in cycles 7–9 → feat_mem_rd low in cycles 7–9. Only the item read in cycle 6 is valid in cycle 7. No valid in cycles 8–10. Streaming resumes with 0x0101 in cycle 11 and no data is lost or duplicated.
- pause held high through the whole LOAD_PARAMS/COMMIT window → parameter loading is unaffected. Output params update in COMMIT as usual. No feat_mem_rd until pause drops.
- start pulsed again mid-stream → ignored: address sequence and output count unchanged, a single stream_done.
- rst asserted during STREAM of plane 1 → all outputs 0 in the same cycle (asynchronous). A following start restarts at address 0 and param address 0.
- H=W=1, C=1 → param reads in cycles 1–4, one feature_valid in cycle 7, stream_done in cycle 8.
